// File: rtl/skip_add_pkg.sv
// Shared types and constants for the skip-add accumulator.
package skip_add_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] SAT_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/skip_add_accumulator_if.sv
// Beat-in / result-out handshake bundle for the skip-add accumulator.
interface skip_add_accumulator_if
  import skip_add_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_carry;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );

endinterface

// File: rtl/carry_skip_adder.sv
// 32-bit carry-skip adder: 4-bit ripple blocks whose carry bypasses a block
// when every bit of that block propagates.
module carry_skip_adder
  import skip_add_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s,
  output logic              c
);

  localparam int BLK  = 4;
  localparam int NBLK = DATA_W / BLK;

  always_comb begin
    logic bc;
    logic rc;
    logic prop;
    s    = '0;
    bc   = 1'b0;
    rc   = 1'b0;
    prop = 1'b0;
    for (int i = 0; i < NBLK; i++) begin
      rc   = bc;
      prop = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        s[i*BLK+j] = a[i*BLK+j] ^ b[i*BLK+j] ^ rc;
        rc         = (a[i*BLK+j] & b[i*BLK+j]) | (rc & (a[i*BLK+j] ^ b[i*BLK+j]));
        prop       = prop & (a[i*BLK+j] ^ b[i*BLK+j]);
      end
      // A fully-propagating block forwards its incoming carry unchanged.
      bc = prop ? bc : rc;
    end
    c = bc;
  end

endmodule

// File: rtl/skip_add_accumulator.sv
// Packet accumulator: sums accepted beats through one carry-skip adder and
// presents sum/sticky carry/beat count until taken. ACC_SAT_EN selects clamping.
module skip_add_accumulator
  import skip_add_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  skip_add_accumulator_if.slave  bus
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic [CNT_W-1:0]  count;
  logic              valid;

  logic [DATA_W-1:0] add_sum;
  logic              add_c;
  logic [DATA_W-1:0] next_acc;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  carry_skip_adder u_adder (
    .a (acc),
    .b (bus.in_data),
    .s (add_sum),
    .c (add_c)
  );

`ifdef ACC_SAT_EN
  // Once any carry has occurred in the packet the sum stays pinned at full scale.
  assign next_acc = (carry || add_c) ? SAT_VALUE : add_sum;
`else
  assign next_acc = add_sum;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= next_acc;
            carry <= carry | add_c;
            count <= sat_inc(count);
            if (bus.in_last) begin
              state <= HOLD;
              valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= IDLE;
            valid <= 1'b0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // Ready is withheld while reset is held so no beat is consumed during it.
  assign bus.in_ready  = rst_n && (state != HOLD);
  assign bus.out_valid = valid;
  assign bus.out_sum   = acc;
  assign bus.out_carry = carry;
  assign bus.out_count = count;

endmodule

// File: tb/tb_skip_add_accumulator.sv
// Directed bench for skip_add_accumulator (wrap and ACC_SAT_EN builds).
module tb_skip_add_accumulator;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  skip_add_accumulator_if #(.CNT_W(8)) bus ();
  skip_add_accumulator_if #(.CNT_W(2)) bus2 ();

  skip_add_accumulator #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  skip_add_accumulator #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

`ifdef ACC_SAT_EN
  localparam logic [31:0] EXP_OVF_SUM = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF_SUM = 32'h0C7B_CD71;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_carry", bus.out_carry, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Two-beat packet, no overflow
    beat(32'h2EEA_AAC8, 1'b0);
    chk("p1_mid_valid", bus.out_valid, 0);
    beat(32'h56A6_7559, 1'b1);
    chk("p1_valid", bus.out_valid, 1);
    chk("p1_sum", bus.out_sum, 32'h8591_2021);
    chk("p1_carry", bus.out_carry, 0);
    chk("p1_count", bus.out_count, 2);
    chk("p1_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("p1_clr_valid", bus.out_valid, 0);
    chk("p1_clr_sum", bus.out_sum, 0);
    chk("p1_clr_count", bus.out_count, 0);
    chk("p1_clr_in_ready", bus.in_ready, 1);

    // out_ready with nothing pending is ignored
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("idle_ready_valid", bus.out_valid, 0);
    chk("idle_ready_in_ready", bus.in_ready, 1);

    // Two-beat packet with carry-out, then held in HOLD with in_valid asserted
    beat(32'h8ED5_6AC8, 1'b0);
    beat(32'h7DA6_62A9, 1'b1);
    chk("p2_valid", bus.out_valid, 1);
    chk("p2_sum", bus.out_sum, EXP_OVF_SUM);
    chk("p2_carry", bus.out_carry, 1);
    chk("p2_count", bus.out_count, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_sum", bus.out_sum, EXP_OVF_SUM);
      chk("hold_count", bus.out_count, 2);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("p2_clr_valid", bus.out_valid, 0);
    chk("p2_clr_carry", bus.out_carry, 0);
    chk("p2_clr_count", bus.out_count, 0);

    // Single-beat packet starts from zero
    beat(32'h0000_ABCD, 1'b1);
    chk("p3_valid", bus.out_valid, 1);
    chk("p3_sum", bus.out_sum, 32'h0000_ABCD);
    chk("p3_carry", bus.out_carry, 0);
    chk("p3_count", bus.out_count, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset mid-packet discards the partial sum
    beat(32'h0000_0001, 1'b0);
    beat(32'h0000_0001, 1'b0);
    beat(32'h0000_0001, 1'b0);
    chk("mid_valid", bus.out_valid, 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_sum", bus.out_sum, 0);
    chk("mid_rst_count", bus.out_count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    step();
    beat(32'h0000_0005, 1'b0);
    beat(32'h0000_0007, 1'b1);
    chk("p4_valid", bus.out_valid, 1);
    chk("p4_sum", bus.out_sum, 32'h0000_000C);
    chk("p4_count", bus.out_count, 2);
    chk("p4_carry", bus.out_carry, 0);

    // Reset while holding a result drops it
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("hold_rst_valid", bus.out_valid, 0);
    chk("hold_rst_sum", bus.out_sum, 0);
    step();
    chk("hold_rst_in_ready", bus.in_ready, 1);

    // Narrow counter saturates
    for (int i = 0; i < 6; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 32'h0000_0001;
      bus2.in_last  = (i == 5);
      step();
    end
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    chk("sat_cnt_valid", bus2.out_valid, 1);
    chk("sat_cnt_count", bus2.out_count, 3);
    chk("sat_cnt_sum", bus2.out_sum, 32'h0000_0006);
    chk("sat_cnt_carry", bus2.out_carry, 0);
    bus2.out_ready = 1'b1;
    step();
    bus2.out_ready = 1'b0;
    chk("sat_cnt_clr_count", bus2.out_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skip_add_accumulator.md
SKIP_ADD_ACCUMULATOR -- requirements
Module: skip_add_accumulator

Interface
REQ-001 Parameter: CNT_W, default 8, width of beat counter out_count.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream beat valid.
REQ-005 Port: in_ready  output  1  block can accept a beat.
REQ-006 Port: in_data  input  32  unsigned operand to accumulate.
REQ-007 Port: in_last  input  1  marks final beat of a packet.
REQ-008 Port: out_valid  output  1  accumulated result valid.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: out_sum  output  32  accumulated sum.
REQ-011 Port: out_carry  output  1  sticky carry-out over the packet.
REQ-012 Port: out_count  output  CNT_W  beats accepted in the packet.

Function
REQ-013 Beat accepted when in_valid && in_ready; no other condition changes accumulator state.
REQ-014 FSM states IDLE, ACCUM, HOLD; IDLE->ACCUM on accepted beat without in_last; IDLE or ACCUM -> HOLD on accepted beat with in_last; ACCUM holds otherwise; HOLD->IDLE on out_ready.
REQ-015 in_ready = 1 in IDLE and ACCUM, 0 in HOLD and while rst_n is low.
REQ-016 Per accepted beat: acc <= 32-bit sum of acc and in_data, computed by carry_skip_adder; carry <= carry | adder carry-out.
REQ-017 Accumulator, carry and count are zero at packet start; the first beat's sum = in_data.
REQ-018 out_count increments per accepted beat, saturating at 2^CNT_W-1 (no wrap).
REQ-019 Latency: out_valid rises the cycle after the in_last beat is accepted; out_sum/out_carry/out_count stable while out_valid = 1.
REQ-020 out_valid = 1 only in HOLD; holds until out_ready sampled 1; then acc, carry, count clear and state = IDLE the next cycle.
REQ-021 out_ready while out_valid = 0 is ignored; in_valid while in_ready = 0 is ignored and the beat is not consumed.
REQ-022 Single-beat packet (in_last on first beat): out_sum = in_data, out_carry = 0, out_count = 1.

Reset
REQ-023 rst_n low at a rising edge, in any state including mid-packet or HOLD: state = IDLE, acc = 0, carry = 0, count = 0, out_valid = 0; the partial packet is discarded.
REQ-024 Reset values: out_sum = 0, out_carry = 0, out_count = 0, out_valid = 0, in_ready = 0 while reset is asserted, then 1 the cycle after release.

Configuration
REQ-025 Macro ACC_SAT_EN defined: on any adder carry-out, acc clamps to 32'hFFFFFFFF and remains there for the rest of the packet; out_carry still reports sticky overflow.
REQ-026 Macro ACC_SAT_EN undefined: acc wraps modulo 2^32; out_carry is sticky.

Structure
REQ-027 Shared package skip_add_pkg holds the FSM state typedef (IDLE/ACCUM/HOLD), DATA_W = 32 and the SAT_VALUE = 32'hFFFFFFFF constant.
REQ-028 One sub-module: carry_skip_adder (existing 32-bit A, B -> S, C), instantiated once with A = acc and B = in_data; no other adders.

Verification
REQ-029 Two-beat packet 0x8ED56AC8, 0x7DA662A9 (last) -> wrap build: out_sum 0x0C7BCD71, out_carry 1, out_count 2; sat build: out_sum 0xFFFFFFFF, out_carry 1.
REQ-030 Two-beat packet 0x2EEAAAC8, 0x56A67559 (last) -> out_sum 0x85912021, out_carry 0, out_count 2, out_valid exactly 1 cycle after the last beat.
REQ-031 out_ready held 0 for 5 cycles in HOLD while in_valid = 1 -> in_ready 0 and outputs constant; out_ready = 1 -> IDLE next cycle, the next packet starts from 0.
REQ-032 rst_n low for 1 cycle after 3 beats of 0x00000001 -> outputs 0; a new packet 0x5, 0x7 (last) -> out_sum 0x0000000C, out_count 2.
REQ-033 CNT_W = 2 with a 6-beat packet of 0x1 -> out_count 3 (saturated), out_sum 0x00000006.
